// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte-stream load, program fetch and status signals of the program loader
interface program_loader_if #(
    parameter int N = 2,
    parameter int W = 8
);
    logic         load_start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [N-1:0] addr;
    logic [W-1:0] instruction;
    logic         cpu_rst;
    logic         busy;
    logic         done;
    logic         error;

    modport master (
        output load_start, in_valid, in_data, addr,
        input  in_ready, instruction, cpu_rst, busy, done, error
    );

    modport slave (
        input  load_start, in_valid, in_data, addr,
        output in_ready, instruction, cpu_rst, busy, done, error
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - writable program store loaded over a byte stream and verified by an XOR checksum
module program_loader #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    program_loader_if.slave bus
);
    localparam int DEPTH = 1 << N;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;

    localparam logic [N:0] LAST_WP = (N+1)'(DEPTH - 1);
    localparam logic [N:0] WP_ONE  = (N+1)'(1);

    logic [2:0]   state;
    logic [W-1:0] mem [DEPTH];
    logic [N:0]   wp;
    logic [W-1:0] csum;
    logic         done_q;
    logic         xfer;

    // A restart request blocks the byte presented in the same cycle.
    assign bus.in_ready = ((state == LOAD) || (state == CHECK)) && !bus.load_start;
    assign xfer         = bus.in_valid && bus.in_ready;

    assign bus.busy        = (state == LOAD) || (state == CHECK);
    assign bus.cpu_rst     = (state != RUN);
    assign bus.error       = (state == ERR);
    assign bus.done        = done_q;
    // An unverified image is never visible to the processor.
    assign bus.instruction = (state == RUN) ? mem[bus.addr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wp     <= '0;
            csum   <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (bus.load_start) begin
                state <= LOAD;
                wp    <= '0;
                csum  <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (xfer) begin
                            mem[wp[N-1:0]] <= bus.in_data;
                            csum           <= csum ^ bus.in_data;
                            wp             <= wp + WP_ONE;
                            if (wp == LAST_WP) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (xfer) begin
                            if (bus.in_data == csum) begin
                                state  <= RUN;
                                done_q <= 1'b1;
                            end else begin
                                state <= ERR;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   xfer_cnt = 0;
    int   done_cnt = 0;

    program_loader_if #(.N(2), .W(8)) bus ();
    program_loader #(.N(2), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) xfer_cnt <= xfer_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic pulse_start();
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (bus.in_ready) got = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL send_byte_accept data=%h got in_ready=0 for 20 cycles required 1", b);
        end
    endtask

    task automatic check_image(input string name, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_img [4];
        exp_img[0] = e0; exp_img[1] = e1; exp_img[2] = e2; exp_img[3] = e3;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 2'(a);
            #1;
            checks++;
            if (bus.instruction !== exp_img[a]) begin
                failures++;
                $display("FAIL %s_instr addr=%0d got %h required %h", name, a, bus.instruction, exp_img[a]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.cpu_rst, bus.in_ready, bus.error, bus.done, bus.busy} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got cpu_rst/in_ready/error/done/busy=%b required 10000",
                     {bus.cpu_rst, bus.in_ready, bus.error, bus.done, bus.busy});
        end
        checks++;
        if (bus.instruction !== 8'h00) begin
            failures++;
            $display("FAIL reset_instr got %h required 00", bus.instruction);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_reset got in_ready=%b cpu_rst=%b required 0 1", bus.in_ready, bus.cpu_rst);
        end
    endtask

    task automatic test_good_load();
        int x0, d0;
        x0 = xfer_cnt; d0 = done_cnt;
        @(negedge clk);
        pulse_start();
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL good_load_state got busy=%b cpu_rst=%b in_ready=%b required 1 1 1",
                     bus.busy, bus.cpu_rst, bus.in_ready);
        end
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h34); send_byte(8'h48);
        checks++;
        if (bus.busy !== 1'b1 || bus.cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL good_load_check_state got busy=%b cpu_rst=%b required 1 1", bus.busy, bus.cpu_rst);
        end
        send_byte(8'h4F);
        checks++;
        if (bus.done !== 1'b1 || bus.cpu_rst !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL good_load_first_run got done=%b cpu_rst=%b busy=%b required 1 0 0",
                     bus.done, bus.cpu_rst, bus.busy);
        end
        bus.addr = 2'd2;
        #1;
        checks++;
        if (bus.instruction !== 8'h34) begin
            failures++;
            $display("FAIL good_load_addr2 got %h required 34", bus.instruction);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL good_load_done_pulse got done=%b required 0 on second RUN cycle", bus.done);
        end
        check_image("good", 8'h11, 8'h22, 8'h34, 8'h48);
        checks++;
        if (xfer_cnt - x0 != 5 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL good_load_counts got xfers=%0d dones=%0d required 5 1", xfer_cnt - x0, done_cnt - d0);
        end
    endtask

    task automatic test_bad_checksum();
        int d0;
        d0 = done_cnt;
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h34); send_byte(8'h48);
        send_byte(8'h00);
        bus.addr = 2'd2;
        #1;
        checks++;
        if (bus.error !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.instruction !== 8'h00 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bad_csum_err got error=%b cpu_rst=%b instr=%h in_ready=%b required 1 1 00 0",
                     bus.error, bus.cpu_rst, bus.instruction, bus.in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || done_cnt != d0) begin
            failures++;
            $display("FAIL bad_csum_sticky got error=%b dones=%0d required 1 0", bus.error, done_cnt - d0);
        end
        pulse_start();
        #1;
        checks++;
        if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL bad_csum_clear got error=%b busy=%b required 0 1", bus.error, bus.busy);
        end
    endtask

    task automatic test_stall();
        int x0, d0;
        logic [7:0] img [4];
        img[0] = 8'h01; img[1] = 8'h23; img[2] = 8'h45; img[3] = 8'h67;
        pulse_start();
        x0 = xfer_cnt; d0 = done_cnt;
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            send_byte(k < 4 ? img[k] : 8'h00);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL stall_done got done=%b cpu_rst=%b required 1 0", bus.done, bus.cpu_rst);
        end
        @(negedge clk);
        check_image("stall", 8'h01, 8'h23, 8'h45, 8'h67);
        checks++;
        if (xfer_cnt - x0 != 5 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL stall_counts got xfers=%0d dones=%0d required 5 1", xfer_cnt - x0, done_cnt - d0);
        end
    endtask

    task automatic test_restart();
        int x0;
        pulse_start();
        x0 = xfer_cnt;
        send_byte(8'hAA); send_byte(8'hBB);
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'hCC;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL restart_ready got in_ready=%b required 0", bus.in_ready);
        end
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        checks++;
        if (xfer_cnt - x0 != 2 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_xfers got xfers=%0d busy=%b required 2 1", xfer_cnt - x0, bus.busy);
        end
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h34); send_byte(8'h48);
        send_byte(8'h4F);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL restart_done got done=%b required 1", bus.done);
        end
        check_image("restart", 8'h11, 8'h22, 8'h34, 8'h48);
    endtask

    task automatic test_reload_and_rst();
        pulse_start();
        bus.addr = 2'd0;
        #1;
        checks++;
        if (bus.cpu_rst !== 1'b1 || bus.instruction !== 8'h00) begin
            failures++;
            $display("FAIL reload_hold got cpu_rst=%b instr=%h required 1 00", bus.cpu_rst, bus.instruction);
        end
        send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h0F); send_byte(8'hF0);
        bus.addr = 2'd1;
        #1;
        checks++;
        if (bus.instruction !== 8'h00 || bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reload_check_state got instr=%h busy=%b in_ready=%b required 00 1 1",
                     bus.instruction, bus.busy, bus.in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1 || bus.in_ready !== 1'b0 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_check got busy=%b cpu_rst=%b in_ready=%b error=%b required 0 1 0 0",
                     bus.busy, bus.cpu_rst, bus.in_ready, bus.error);
        end
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (dut.mem[a] !== 8'h00) begin
                failures++;
                $display("FAIL rst_mem_clear addr=%0d got %h required 00", a, dut.mem[a]);
            end
        end
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.addr       = 2'd0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_stall();
        test_restart();
        test_reload_and_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
